// File: rtl/ov5640_dvp_capture.sv
// OV5640 DVP capture: registers vsync/href/data on pclk, packs byte pairs into RGB565 words and checks frame geometry.
// Latency: 3 clk from the second byte of a pair at the pins to the write strobe; frame_done 2 clk after vsync rises at the pins.
// Backpressure: none (the sensor cannot be stalled); the downstream FIFO must absorb one word every two pclk cycles.
//
// Ports:
//   clk, rest_n                     pixel clock, asynchronous active-low reset
//   enable                          capture enable (level); dropping it aborts the frame, raising it re-arms frame skipping
//   ov5640_vsync/href/data          raw sensor DVP bus
//   write, write_data               one-cycle strobe with packed 16-bit word
//   addr_clean                      level request to reset the FIFO/frame address (high whenever no frame is active)
//   frame_done, frame_cnt           end-of-frame pulse and wrapping count of captured frames
//   geom_err                        sticky line/frame length or odd-byte error
module ov5640_dvp_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 10,
    parameter bit VSYNC_POL   = 1'b1,
    parameter bit HI_FIRST    = 1'b1
) (
    input  logic        clk,
    input  logic        rest_n,
    input  logic        enable,
    input  logic        ov5640_vsync,
    input  logic        ov5640_href,
    input  logic [7:0]  ov5640_data,
    output logic        write,
    output logic [15:0] write_data,
    output logic        addr_clean,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic        geom_err
);

    localparam logic [10:0] LP_H    = 11'(H_ACTIVE);
    localparam logic [9:0]  LP_V    = 10'(V_ACTIVE);
    localparam logic [7:0]  LP_SKIP = 8'(SKIP_FRAMES);

    typedef enum logic [1:0] {
        ST_SKIP = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2,
        ST_END  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_vs;
    logic        r_vs_d;
    logic        r_href;
    logic [7:0]  r_data;
    logic        r_en_d;
    logic [7:0]  r_skip_cnt;
    logic        r_phase;
    logic        r_in_line;
    logic [7:0]  r_byte0;
    logic [15:0] r_word;
    logic        r_word_vld;
    logic [10:0] r_pix_cnt;
    logic [9:0]  r_line_cnt;

    logic w_vs_rise;
    logic w_vs_fall;
    logic w_en_rise;
    logic w_pack;
    logic w_line_end;

    assign w_vs_rise  = r_vs & ~r_vs_d;
    assign w_vs_fall  = ~r_vs & r_vs_d;
    assign w_en_rise  = enable & ~r_en_d;
    // Bytes are only accepted inside an active frame (vs inactive) while capturing.
    assign w_pack     = (r_state == ST_CAPT) & r_href & ~r_vs;
    // A line closes when href drops, or when vsync goes active under a still-high href.
    assign w_line_end = (r_state == ST_CAPT) & r_in_line & (~r_href | r_vs);

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            r_state    <= ST_SKIP;
            r_vs       <= 1'b0;
            r_vs_d     <= 1'b0;
            r_href     <= 1'b0;
            r_data     <= 8'd0;
            r_en_d     <= 1'b0;
            r_skip_cnt <= 8'd0;
            r_phase    <= 1'b0;
            r_in_line  <= 1'b0;
            r_byte0    <= 8'd0;
            r_word     <= 16'd0;
            r_word_vld <= 1'b0;
            r_pix_cnt  <= 11'd0;
            r_line_cnt <= 10'd0;
            write      <= 1'b0;
            write_data <= 16'd0;
            addr_clean <= 1'b1;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            geom_err   <= 1'b0;
        end else begin
            r_vs       <= ov5640_vsync ^ ~VSYNC_POL;
            r_vs_d     <= r_vs;
            r_href     <= ov5640_href;
            r_data     <= ov5640_data;
            r_en_d     <= enable;
            r_word_vld <= 1'b0;
            frame_done <= 1'b0;

            // Output stage: a word packed while capturing is only released if capture is still live.
            write <= r_word_vld & (r_state == ST_CAPT) & enable;
            if (r_word_vld && (r_state == ST_CAPT) && enable) begin
                write_data <= r_word;
            end

            if (!enable) begin
                r_state    <= ST_WAIT;
                addr_clean <= 1'b1;
                r_phase    <= 1'b0;
                r_in_line  <= 1'b0;
            end else if (w_en_rise) begin
                r_state    <= ST_SKIP;
                r_skip_cnt <= 8'd0;
                addr_clean <= 1'b1;
                r_phase    <= 1'b0;
                r_in_line  <= 1'b0;
            end else begin
                case (r_state)
                    ST_SKIP: begin
                        addr_clean <= 1'b1;
                        if (r_skip_cnt == LP_SKIP) begin
                            r_state <= ST_WAIT;
                        end else if (w_vs_fall) begin
                            r_skip_cnt <= r_skip_cnt + 8'd1;
                        end
                    end
                    ST_WAIT: begin
                        addr_clean <= 1'b1;
                        // Only a vsync fall guarantees we start at the top of a frame.
                        if (w_vs_fall) begin
                            r_state    <= ST_CAPT;
                            addr_clean <= 1'b0;
                            r_line_cnt <= 10'd0;
                            r_pix_cnt  <= 11'd0;
                            r_phase    <= 1'b0;
                            r_in_line  <= 1'b0;
                        end
                    end
                    ST_CAPT: begin
                        addr_clean <= r_vs;
                        if (w_pack) begin
                            r_in_line <= 1'b1;
                            if (!r_phase) begin
                                r_byte0 <= r_data;
                                r_phase <= 1'b1;
                            end else begin
                                r_phase    <= 1'b0;
                                r_word     <= HI_FIRST ? {r_byte0, r_data} : {r_data, r_byte0};
                                r_word_vld <= 1'b1;
                                if (r_pix_cnt != 11'h7FF) begin
                                    r_pix_cnt <= r_pix_cnt + 11'd1;
                                end
                            end
                        end else if (w_line_end) begin
                            // A pending half word is simply dropped.
                            r_in_line <= 1'b0;
                            r_phase   <= 1'b0;
                            r_pix_cnt <= 11'd0;
                            if (r_phase || (r_pix_cnt != LP_H)) begin
                                geom_err <= 1'b1;
                            end
                            if (r_line_cnt != 10'h3FF) begin
                                r_line_cnt <= r_line_cnt + 10'd1;
                            end
                        end else begin
                            r_phase <= 1'b0;
                        end
                        if (w_vs_rise) begin
                            r_state    <= ST_END;
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                            addr_clean <= 1'b1;
                        end
                    end
                    ST_END: begin
                        // Line count was finalised on the vs_rise cycle.
                        addr_clean <= 1'b1;
                        if (r_line_cnt != LP_V) begin
                            geom_err <= 1'b1;
                        end
                        r_state    <= ST_CAPT;
                        r_line_cnt <= 10'd0;
                        r_pix_cnt  <= 11'd0;
                    end
                    default: r_state <= ST_SKIP;
                endcase
            end
        end
    end

endmodule
